// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage front end; decodes a command into an ALU control code,
//   registers operands toward the combinational ALU and returns the captured result.
// Latency: response visible 2 cycles after the accept cycle (1 cycle for reserved kind);
//   minimum issue interval is 3 cycles.
// Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready is only high in IDLE.
//
// Ports: clk/rst_n (async active-low); cmd_* command channel (valid/ready);
//   alu_a/alu_b/alu_ctrl drive the ALU, alu_out/alu_zero come back from it;
//   rsp_* response channel (valid/ready); busy = not idle; op_cnt = completed responses.
// Optional build macro GREEN_OPERAND_HOLD_EN: when defined, ALU inputs hold their last
//   values while idle; when undefined they are cleared to zero on returning to IDLE.

module alu_issue_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_kind,
   input  logic [2:0]       cmd_funct,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] KIND_RTYPE = 2'b00;
   localparam logic [1:0] KIND_LDST  = 2'b01;
   localparam logic [1:0] KIND_BR    = 2'b10;

   localparam logic [3:0] CTRL_ADD = 4'b0000;
   localparam logic [3:0] CTRL_SUB = 4'b0001;

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] alu_a_q,     alu_a_d;
   logic [WIDTH-1:0] alu_b_q,     alu_b_d;
   logic [3:0]       alu_ctrl_q,  alu_ctrl_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic             rsp_zero_q,  rsp_zero_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [CNT_W-1:0] op_cnt_q,    op_cnt_d;

   logic [3:0] ctrl_dec;
   logic       cmd_fire;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;

   // Load/store uses ADD for address calculation, branches use SUB for compare.
   always_comb begin
      ctrl_dec = CTRL_ADD;
      case (cmd_kind)
         KIND_RTYPE: ctrl_dec = {1'b0, cmd_funct};
         KIND_LDST:  ctrl_dec = CTRL_ADD;
         KIND_BR:    ctrl_dec = CTRL_SUB;
         default:    ctrl_dec = CTRL_ADD;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ctrl_d  = alu_ctrl_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_err_d   = rsp_err_q;
      op_cnt_d    = op_cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (cmd_kind == 2'b11) begin
                  // Reserved kind skips the ALU entirely; its inputs stay untouched.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_zero_d  = 1'b0;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d    = EXEC;
                  alu_a_d    = cmd_a;
                  alu_b_d    = cmd_b;
                  alu_ctrl_d = ctrl_dec;
               end
            end
         end

         EXEC: begin
            // ALU has had a full cycle to settle from the registered operands.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_out;
            rsp_zero_d  = alu_zero;
            rsp_err_d   = 1'b0;
         end

         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               op_cnt_d    = op_cnt_q + CNT_W'(1);
`ifndef GREEN_OPERAND_HOLD_EN
               // Deterministic ALU inputs while idle.
               alu_a_d     = '0;
               alu_b_d     = '0;
               alu_ctrl_d  = CTRL_ADD;
`endif
            end
         end

         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= CTRL_ADD;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         op_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_err_q   <= rsp_err_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_err   = rsp_err_q;
   assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural 16-bit ALU attached.
// Expected responses (data, zero, err, first-valid cycle) are queued at command accept;
// a negedge monitor compares every cycle the response is presented and pops on handshake.

module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_kind;
   logic [2:0]  cmd_funct;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [15:0] alu_out;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;
   logic [15:0] op_cnt;

   alu_issue_ctrl #(.WIDTH(16), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_funct (cmd_funct),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_ctrl  (alu_ctrl),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .op_cnt    (op_cnt)
   );

   // Behavioural ALU the block drives.
   always_comb begin
      alu_out = 16'h0000;
      case (alu_ctrl)
         4'd0: alu_out = alu_a + alu_b;
         4'd1: alu_out = alu_a - alu_b;
         4'd2: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
         4'd3: alu_out = alu_a | alu_b;
         4'd4: alu_out = alu_a & alu_b;
         4'd5: alu_out = alu_a >> alu_b[3:0];
         4'd6: alu_out = alu_a << alu_b[3:0];
         4'd7: alu_out = $unsigned($signed(alu_a) >>> alu_b[3:0]);
         default: alu_out = 16'h0000;
      endcase
   end
   assign alu_zero = (alu_out == 16'h0000);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      logic        zero;
      logic        err;
      int unsigned vld_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;
   bit   seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from where the DUT updates.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen    = 0;
         exp_cnt = 0;
      end else if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 with data 0x%0h, expected no response", rsp_data);
         end else begin
            if (!seen) begin
               chk("rsp_latency_cycle", cyc, exp_q[0].vld_cyc);
               seen = 1;
            end
            chk("rsp_data", rsp_data, exp_q[0].data);
            chk("rsp_zero", rsp_zero, exp_q[0].zero);
            chk("rsp_err", rsp_err, exp_q[0].err);
            chk("cmd_ready_in_resp", cmd_ready, 1'b0);
            chk("busy_in_resp", busy, 1'b1);
            chk("op_cnt_before_hs", op_cnt, exp_cnt);
            if (rsp_ready) begin
               void'(exp_q.pop_front());
               exp_cnt++;
               seen = 0;
            end
         end
      end
   end

   // Issue one command once the block is ready; inputs change 2 time units after posedge.
   task automatic issue(input logic [1:0] kind, input logic [2:0] funct,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ez, input logic ee,
                        input logic [3:0] ectrl, input logic [15:0] ea, input logic [15:0] eb);
      exp_t e;
      bit   ok;
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #2;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cmd_ready_timeout: got cmd_ready=0, expected 1 within 30 cycles");
         return;
      end
      cmd_kind  = kind;
      cmd_funct = funct;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      e.data    = ed;
      e.zero    = ez;
      e.err     = ee;
      // Normal commands spend one EXEC cycle before RESP; reserved goes straight to RESP.
      e.vld_cyc = ee ? cyc : cyc + 1;
      exp_q.push_back(e);
      chk("alu_a_after_accept", alu_a, ea);
      chk("alu_b_after_accept", alu_b, eb);
      chk("alu_ctrl_after_accept", alu_ctrl, ectrl);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_kind  = 2'b00;
      cmd_funct = 3'b000;
      cmd_a     = 16'h0000;
      cmd_b     = 16'h0000;
      rsp_ready = 1'b1;

      // 1. Reset
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 16'h0000);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_alu_a", alu_a, 16'h0000);
      chk("rst_alu_ctrl", alu_ctrl, 4'h0);
      chk("rst_op_cnt", op_cnt, 16'h0000);
      @(posedge clk);
      #2;

      // 2. R-type ADD
      issue(2'b00, 3'b000, 16'h1234, 16'h0111, 16'h1345, 1'b0, 1'b0, 4'h0, 16'h1234, 16'h0111);
      drain();
      chk("op_cnt_after_add", op_cnt, 16'd1);

      // 3. Branch SUB equal operands, then signed SLT
      issue(2'b10, 3'b101, 16'h00AA, 16'h00AA, 16'h0000, 1'b1, 1'b0, 4'h1, 16'h00AA, 16'h00AA);
      drain();
      issue(2'b00, 3'b010, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 4'h2, 16'hFFFF, 16'h0001);
      drain();

      // 4. Reserved kind: ALU inputs keep whatever they held while idle
`ifdef GREEN_OPERAND_HOLD_EN
      issue(2'b11, 3'b000, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h2, 16'hFFFF, 16'h0001);
`else
      issue(2'b11, 3'b000, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000);
`endif
      drain();

      // Load/store address add (funct ignored) and SLL
      issue(2'b01, 3'b101, 16'h0100, 16'h0020, 16'h0120, 1'b0, 1'b0, 4'h0, 16'h0100, 16'h0020);
      drain();
      issue(2'b00, 3'b110, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 4'h6, 16'h0001, 16'h0004);
      drain();

      // 5. Back-pressure on SRA
      rsp_ready = 1'b0;
      issue(2'b00, 3'b111, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 4'h7, 16'h8000, 16'h0004);
      repeat (6) @(posedge clk);
      #2;
      chk("bp_rsp_still_valid", rsp_valid, 1'b1);
      chk("bp_op_cnt_held", op_cnt, 16'd6);
      rsp_ready = 1'b1;
      drain();
      chk("op_cnt_after_bp", op_cnt, 16'd7);
`ifdef GREEN_OPERAND_HOLD_EN
      chk("idle_alu_a", alu_a, 16'h8000);
      chk("idle_alu_ctrl", alu_ctrl, 4'h7);
`else
      chk("idle_alu_a", alu_a, 16'h0000);
      chk("idle_alu_ctrl", alu_ctrl, 4'h0);
`endif

      // 6. Reset during EXEC: command dropped, no response
      cmd_kind  = 2'b00;
      cmd_funct = 3'b011;
      cmd_a     = 16'h0F0F;
      cmd_b     = 16'h00F0;
      cmd_valid = 1'b1;
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
      chk("exec_busy", busy, 1'b1);
      chk("exec_alu_a", alu_a, 16'h0F0F);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      chk("midrst_alu_a", alu_a, 16'h0000);
      chk("midrst_alu_ctrl", alu_ctrl, 4'h0);
      chk("midrst_op_cnt", op_cnt, 16'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #2;
         chk("postrst_no_rsp", rsp_valid, 1'b0);
      end

      // Post-reset ADD with wraparound result of zero
      issue(2'b00, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'h0, 16'hFFFF, 16'h0001);
      drain();
      chk("op_cnt_final", op_cnt, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
